// File: rtl/dp_scale_accum.sv
// dp_scale_accum: accumulates N_TILES block-scaled partial dot products
// (value * 2^scale) into one normalised (acc, scale) result, presented to the
// next stage behind a valid/ready handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. o_ready and o_valid are decoded from the
// FSM state only, so neither depends combinationally on i_valid or i_ready.
// The input side also requires i_clear low for a beat to be accepted.
module dp_scale_accum #(
  parameter int IN_WIDTH    = 18,
  parameter int SCALE_WIDTH = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int N_TILES     = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [IN_WIDTH-1:0]    i_dp,
  input  logic [SCALE_WIDTH-1:0] i_scale,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_clear,
  output logic [ACC_WIDTH-1:0]   o_acc,
  output logic [SCALE_WIDTH-1:0] o_scale,
  output logic                   o_ovf,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_dbg_state
);

  localparam int CNT_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TILES - 1);

  localparam logic signed [SCALE_WIDTH-1:0] SCALE_MAX = {1'b0, {(SCALE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0]   ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0]   ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]              cnt;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic signed [SCALE_WIDTH-1:0] scale_q;
  logic                          ovf_q;

  logic accept;
  logic last_beat;

  // Aligned-add datapath signals
  logic signed [ACC_WIDTH-1:0]   dp_ext;
  logic signed [SCALE_WIDTH:0]   d;
  logic [SCALE_WIDTH:0]          sh_amt;
  logic                          sh_big;
  logic signed [ACC_WIDTH-1:0]   small_op;
  logic signed [ACC_WIDTH-1:0]   big_op;
  logic signed [ACC_WIDTH-1:0]   shifted;
  logic signed [SCALE_WIDTH-1:0] res_scale;
  logic signed [ACC_WIDTH:0]     sum;
  logic                          sum_ovf;
  logic signed [ACC_WIDTH-1:0]   add_acc;
  logic signed [SCALE_WIDTH-1:0] add_scale;
  logic                          add_sat;

  // Next accumulator contents for an accepted beat
  logic signed [ACC_WIDTH-1:0]   acc_nxt;
  logic signed [SCALE_WIDTH-1:0] scale_nxt;
  logic                          ovf_nxt;

  assign accept    = i_valid & (state == S_ACC) & ~i_clear;
  assign last_beat = (cnt == CNT_LAST);

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: leave S_ACC on the final beat, leave S_OUT on handshake
  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (accept && last_beat) state_nxt = S_OUT;
      S_OUT:   if (i_ready) state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  // FSM outputs decoded from state only
  always_comb begin
    o_ready     = (state == S_ACC);
    o_valid     = (state == S_OUT);
    o_dbg_state = state;
  end

  // Aligned add: shift the smaller-scale operand, sum, renormalise or saturate
  always_comb begin
    dp_ext = {{(ACC_WIDTH-IN_WIDTH){i_dp[IN_WIDTH-1]}}, i_dp};
    d      = $signed({i_scale[SCALE_WIDTH-1], i_scale}) - $signed({scale_q[SCALE_WIDTH-1], scale_q});
    sh_amt = d[SCALE_WIDTH] ? $unsigned(-d) : $unsigned(d);
    sh_big = ({{(31-SCALE_WIDTH){1'b0}}, sh_amt} >= 32'(ACC_WIDTH));

    // Negative d means the incoming beat has the smaller scale
    if (d[SCALE_WIDTH]) begin
      small_op  = dp_ext;
      big_op    = acc_q;
      res_scale = scale_q;
    end else begin
      small_op  = acc_q;
      big_op    = dp_ext;
      res_scale = i_scale;
    end

    // Oversized shifts collapse to the sign of the operand
    if (sh_big) begin
      shifted = {ACC_WIDTH{small_op[ACC_WIDTH-1]}};
    end else begin
      shifted = small_op >>> sh_amt;
    end

    sum     = {shifted[ACC_WIDTH-1], shifted} + {big_op[ACC_WIDTH-1], big_op};
    sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

    add_acc   = sum[ACC_WIDTH-1:0];
    add_scale = res_scale;
    add_sat   = 1'b0;
    if (sum_ovf) begin
      if (res_scale == SCALE_MAX) begin
        // Exponent cannot grow any further: clamp the mantissa instead
        add_acc = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        add_sat = 1'b1;
      end else begin
        add_acc   = sum[ACC_WIDTH:1];
        add_scale = res_scale + SCALE_WIDTH'(1);
      end
    end
  end

  // First beat of a group loads, later beats accumulate
  always_comb begin
    if (cnt == '0) begin
      acc_nxt   = dp_ext;
      scale_nxt = i_scale;
      ovf_nxt   = 1'b0;
    end else begin
      acc_nxt   = add_acc;
      scale_nxt = add_scale;
      ovf_nxt   = ovf_q | add_sat;
    end
  end

  // Beat counter and running accumulator; i_clear discards the partial group
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      acc_q   <= '0;
      scale_q <= '0;
      ovf_q   <= 1'b0;
    end else if (state == S_ACC) begin
      if (i_clear) begin
        cnt <= '0;
      end else if (i_valid) begin
        acc_q   <= acc_nxt;
        scale_q <= scale_nxt;
        ovf_q   <= ovf_nxt;
        cnt     <= last_beat ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  // Result registers change only when a group completes, so they hold under backpressure
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_acc   <= '0;
      o_scale <= '0;
      o_ovf   <= 1'b0;
    end else if (accept && last_beat) begin
      o_acc   <= acc_nxt;
      o_scale <= scale_nxt;
      o_ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_dp_scale_accum.sv
// Testbench for dp_scale_accum. Three instances: default parameters,
// N_TILES=2, and ACC_WIDTH=19. Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
module tb_dp_scale_accum;

  localparam int SMAX = 127;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus
  logic [17:0] dp;
  logic [7:0]  scale_in;
  logic        clear;
  logic        ready;
  logic        valid_def, valid_n2, valid_a19;

  // Instance outputs
  logic [31:0] acc_def, acc_n2;
  logic [18:0] acc_a19;
  logic [7:0]  sc_def, sc_n2, sc_a19;
  logic        ovf_def, ovf_n2, ovf_a19;
  logic        ov_def, ov_n2, ov_a19;
  logic        rdy_def, rdy_n2, rdy_a19;
  logic        st_def, st_n2, st_a19;

  dp_scale_accum u_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_dp(dp), .i_scale(scale_in), .i_valid(valid_def),
    .o_ready(rdy_def), .i_clear(clear), .o_acc(acc_def), .o_scale(sc_def), .o_ovf(ovf_def),
    .o_valid(ov_def), .i_ready(ready), .o_dbg_state(st_def)
  );

  dp_scale_accum #(.N_TILES(2)) u_n2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_dp(dp), .i_scale(scale_in), .i_valid(valid_n2),
    .o_ready(rdy_n2), .i_clear(clear), .o_acc(acc_n2), .o_scale(sc_n2), .o_ovf(ovf_n2),
    .o_valid(ov_n2), .i_ready(ready), .o_dbg_state(st_n2)
  );

  dp_scale_accum #(.ACC_WIDTH(19)) u_a19 (
    .i_clk(clk), .i_rst_n(rst_n), .i_dp(dp), .i_scale(scale_in), .i_valid(valid_a19),
    .o_ready(rdy_a19), .i_clear(clear), .o_acc(acc_a19), .o_scale(sc_a19), .o_ovf(ovf_a19),
    .o_valid(ov_a19), .i_ready(ready), .o_dbg_state(st_a19)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard: {acc[63:0], scale[7:0], ovf}
  logic [72:0] exp_q[$];

  // Current group for the reference model
  longint gv[$];
  int     gs[$];

  // ---------------- reference model ----------------
  // value * 2^-n rounded toward -inf; shifts of aw or more give the sign only
  function automatic longint floor_shift(input longint v, input int n, input int aw);
    longint p;
    if (n >= aw) return (v < 0) ? -1 : 0;
    p = longint'(1) << n;
    if (v >= 0) return v / p;
    return -(((-v) + p - 1) / p);
  endfunction

  function automatic void model_group(input int aw, output longint racc, output int rsc, output bit rovf);
    longint a, b, s, maxv, minv;
    int nsc;
    maxv = (longint'(1) << (aw - 1)) - 1;
    minv = -(longint'(1) << (aw - 1));
    racc = gv[0];
    rsc  = gs[0];
    rovf = 1'b0;
    for (int i = 1; i < gv.size(); i++) begin
      if (gs[i] >= rsc) begin
        a = floor_shift(racc, gs[i] - rsc, aw);
        b = gv[i];
        nsc = gs[i];
      end else begin
        a = floor_shift(gv[i], rsc - gs[i], aw);
        b = racc;
        nsc = rsc;
      end
      s = a + b;
      if (s > maxv || s < minv) begin
        if (nsc == SMAX) begin
          s = (s < 0) ? minv : maxv;
          rovf = 1'b1;
        end else begin
          s = floor_shift(s, 1, 64);
          nsc = nsc + 1;
        end
      end
      racc = s;
      rsc  = nsc;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_valid(input int sel, input logic v);
    case (sel)
      0: valid_def = v;
      1: valid_n2  = v;
      default: valid_a19 = v;
    endcase
  endtask

  task automatic drive_beat(input int sel, input longint v, input int s);
    logic [63:0] vb;
    logic [31:0] sb;
    vb = v;
    sb = s;
    dp = vb[17:0];
    scale_in = sb[7:0];
    set_valid(sel, 1'b1);
    @(negedge clk);
    set_valid(sel, 1'b0);
  endtask

  task automatic get_out(input int sel, output longint a, output int s, output bit ov,
                         output bit vl, output bit rd);
    case (sel)
      0: begin a = longint'($signed(acc_def)); s = int'($signed(sc_def)); ov = ovf_def; vl = ov_def; rd = rdy_def; end
      1: begin a = longint'($signed(acc_n2));  s = int'($signed(sc_n2));  ov = ovf_n2;  vl = ov_n2;  rd = rdy_n2;  end
      default: begin a = longint'($signed(acc_a19)); s = int'($signed(sc_a19)); ov = ovf_a19; vl = ov_a19; rd = rdy_a19; end
    endcase
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    longint a; int s; bit ov, vl, rd;
    for (int sel = 0; sel < 3; sel++) begin
      get_out(sel, a, s, ov, vl, rd);
      checks++;
      if (a !== 0 || s !== 0 || ov !== 1'b0 || vl !== 1'b0 || rd !== 1'b1) begin
        errors++;
        $display("FAIL reset[%0d]: got acc=%0d scale=%0d ovf=%0b valid=%0b ready=%0b, expected 0 0 0 0 1",
                 sel, a, s, ov, vl, rd);
      end
    end
  endtask

  task automatic test_equal_scales();
    longint a; int s; bit ov, vl, rd;
    drive_beat(0, 10, 3);
    drive_beat(0, 20, 3);
    drive_beat(0, -5, 3);
    get_out(0, a, s, ov, vl, rd);
    checks++;
    if (vl !== 1'b0 || rd !== 1'b1) begin
      errors++;
      $display("FAIL equal_early_valid: got valid=%0b ready=%0b, expected 0 1", vl, rd);
    end
    drive_beat(0, 7, 3);
    get_out(0, a, s, ov, vl, rd);
    checks++;
    if (a !== 32 || s !== 3 || ov !== 1'b0 || vl !== 1'b1 || rd !== 1'b0) begin
      errors++;
      $display("FAIL equal_result: got acc=%0d scale=%0d ovf=%0b valid=%0b ready=%0b, expected 32 3 0 1 0",
               a, s, ov, vl, rd);
    end
    @(negedge clk);
    get_out(0, a, s, ov, vl, rd);
    checks++;
    if (vl !== 1'b0 || rd !== 1'b1) begin
      errors++;
      $display("FAIL equal_after_handshake: got valid=%0b ready=%0b, expected 0 1", vl, rd);
    end
  endtask

  task automatic test_alignment();
    longint a; int s; bit ov, vl, rd;
    drive_beat(0, 8, 0);
    drive_beat(0, 3, 2);
    drive_beat(0, 1, 2);
    drive_beat(0, 4, 1);
    get_out(0, a, s, ov, vl, rd);
    checks++;
    if (a !== 8 || s !== 2 || ov !== 1'b0 || vl !== 1'b1) begin
      errors++;
      $display("FAIL align_mixed: got acc=%0d scale=%0d ovf=%0b valid=%0b, expected 8 2 0 1", a, s, ov, vl);
    end
    @(negedge clk);
    drive_beat(1, -1, 0);
    drive_beat(1, 0, 100);
    get_out(1, a, s, ov, vl, rd);
    checks++;
    if (a !== -1 || s !== 100 || ov !== 1'b0 || vl !== 1'b1) begin
      errors++;
      $display("FAIL align_clamp: got acc=%0d scale=%0d ovf=%0b valid=%0b, expected -1 100 0 1", a, s, ov, vl);
    end
    @(negedge clk);
  endtask

  task automatic test_renormalise();
    longint a; int s; bit ov, vl, rd;
    for (int i = 0; i < 4; i++) drive_beat(2, 131071, 0);
    get_out(2, a, s, ov, vl, rd);
    checks++;
    if (a !== 262141 || s !== 1 || ov !== 1'b0 || vl !== 1'b1) begin
      errors++;
      $display("FAIL renorm: got acc=%0d scale=%0d ovf=%0b valid=%0b, expected 262141 1 0 1", a, s, ov, vl);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    longint a; int s; bit ov, vl, rd;
    for (int i = 0; i < 4; i++) drive_beat(2, 131071, 127);
    get_out(2, a, s, ov, vl, rd);
    checks++;
    if (a !== 262143 || s !== 127 || ov !== 1'b1 || vl !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got acc=%0d scale=%0d ovf=%0b valid=%0b, expected 262143 127 1 1", a, s, ov, vl);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive_beat(2, 1, 0);
    get_out(2, a, s, ov, vl, rd);
    checks++;
    if (a !== 4 || s !== 0 || ov !== 1'b0 || vl !== 1'b1) begin
      errors++;
      $display("FAIL saturate_next_group: got acc=%0d scale=%0d ovf=%0b valid=%0b, expected 4 0 0 1", a, s, ov, vl);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    longint a; int s; bit ov, vl, rd;
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) drive_beat(0, i, 0);
    dp = 18'd99;
    scale_in = 8'd0;
    valid_def = 1'b1;
    for (int c = 0; c < 5; c++) begin
      get_out(0, a, s, ov, vl, rd);
      checks++;
      if (a !== 10 || s !== 0 || ov !== 1'b0 || vl !== 1'b1 || rd !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got acc=%0d scale=%0d ovf=%0b valid=%0b ready=%0b, expected 10 0 0 1 0",
                 c, a, s, ov, vl, rd);
      end
      @(negedge clk);
    end
    valid_def = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive_beat(0, 2, 0);
    get_out(0, a, s, ov, vl, rd);
    checks++;
    if (a !== 8 || s !== 0 || vl !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_next_group: got acc=%0d scale=%0d valid=%0b, expected 8 0 1", a, s, vl);
    end
    @(negedge clk);
  endtask

  task automatic test_clear_and_reset();
    longint a; int s; bit ov, vl, rd;
    drive_beat(0, 5, 0);
    drive_beat(0, 6, 0);
    clear = 1'b1;
    drive_beat(0, 50, 0);
    clear = 1'b0;
    drive_beat(0, 1, 0);
    drive_beat(0, 1, 0);
    get_out(0, a, s, ov, vl, rd);
    checks++;
    if (vl !== 1'b0) begin
      errors++;
      $display("FAIL clear_count: got valid=%0b after 2 post-clear beats, expected 0", vl);
    end
    ready = 1'b0;
    drive_beat(0, 1, 0);
    drive_beat(0, 1, 0);
    get_out(0, a, s, ov, vl, rd);
    checks++;
    if (a !== 4 || s !== 0 || vl !== 1'b1) begin
      errors++;
      $display("FAIL clear_result: got acc=%0d scale=%0d valid=%0b, expected 4 0 1", a, s, vl);
    end
    // clear while a result waits must not drop it
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    get_out(0, a, s, ov, vl, rd);
    checks++;
    if (a !== 4 || vl !== 1'b1) begin
      errors++;
      $display("FAIL clear_in_out: got acc=%0d valid=%0b, expected 4 1", a, vl);
    end
    // asynchronous reset in S_OUT, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    get_out(0, a, s, ov, vl, rd);
    checks++;
    if (a !== 0 || s !== 0 || ov !== 1'b0 || vl !== 1'b0 || rd !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got acc=%0d scale=%0d ovf=%0b valid=%0b ready=%0b, expected 0 0 0 0 1",
               a, s, ov, vl, rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive_beat(0, 3, 0);
    get_out(0, a, s, ov, vl, rd);
    checks++;
    if (a !== 12 || vl !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_group: got acc=%0d valid=%0b, expected 12 1", a, vl);
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int sel, input int aw, input int groups);
    longint a, ea, ha; int s, es, hs; bit ov, vl, rd, eo;
    logic [72:0] e;
    logic [17:0] r18;
    int n, wait_cnt;
    n = (sel == 1) ? 2 : 4;
    for (int g = 0; g < groups; g++) begin
      gv.delete();
      gs.delete();
      for (int i = 0; i < n; i++) begin
        r18 = 18'($urandom);
        gv.push_back(longint'($signed(r18)));
        case ($urandom_range(0, 3))
          0: gs.push_back(int'($urandom_range(0, 255)) - 128);
          1: gs.push_back(int'($urandom_range(120, 127)));
          default: gs.push_back(int'($urandom_range(0, 20)) - 10);
        endcase
      end
      model_group(aw, ea, es, eo);
      exp_q.push_back({ea, es[7:0], eo});
      ready = 1'b0;
      for (int i = 0; i < n; i++) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) @(negedge clk);
        drive_beat(sel, gv[i], gs[i]);
      end
      wait_cnt = 0;
      get_out(sel, a, s, ov, vl, rd);
      while (!vl && wait_cnt < 10) begin
        @(negedge clk);
        wait_cnt++;
        get_out(sel, a, s, ov, vl, rd);
      end
      checks++;
      if (!vl) begin
        errors++;
        $display("FAIL random_timeout[%0d]: valid still 0 after 10 cycles", g);
      end
      ha = a;
      hs = s;
      for (int k = $urandom_range(0, 3); k > 0; k--) @(negedge clk);
      get_out(sel, a, s, ov, vl, rd);
      checks++;
      if (a !== ha || s !== hs || vl !== 1'b1) begin
        errors++;
        $display("FAIL random_hold[%0d]: got acc=%0d scale=%0d valid=%0b, expected %0d %0d 1", g, a, s, vl, ha, hs);
      end
      e = exp_q.pop_front();
      ea = longint'(e[72:9]);
      es = int'($signed(e[8:1]));
      eo = e[0];
      checks++;
      if (a !== ea || s !== es || ov !== eo) begin
        errors++;
        $display("FAIL random_result[%0d/%0d]: got acc=%0d scale=%0d ovf=%0b, expected %0d %0d %0b",
                 sel, g, a, s, ov, ea, es, eo);
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
    end
    ready = 1'b1;
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n = 1'b0;
    dp = '0;
    scale_in = '0;
    clear = 1'b0;
    ready = 1'b1;
    valid_def = 1'b0;
    valid_n2 = 1'b0;
    valid_a19 = 1'b0;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_equal_scales();
    test_alignment();
    test_renormalise();
    test_saturation();
    test_backpressure();
    test_clear_and_reset();
    test_random(0, 32, 40);
    test_random(1, 32, 30);
    test_random(2, 19, 40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
